mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-stage data access unit of the MIPS pipeline. Sits between the EX/MEM register and M_WB: converts the M-stage load/store into a handshaked word-bus transaction with byte enables, stalls the pipeline until the transaction completes, and produces the aligned, extended load data (`mem_read_M`) that M_WB captures. Also gates the register-write enable so M_WB only sees a write on the cycle the result is valid.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width (fixed at 32; byte-lane logic assumes 4 lanes).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous active-high reset
- `MemR_M`  in  1  load in M stage
- `MemW_M`  in  1  store in M stage
- `size_M`  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- `unsigned_M`  in  1  zero-extend loads (LBU/LHU)
- `ALU_result_M`  in  32  effective address
- `write_data_M`  in  32  store data (low-aligned)
- `RegW_enable_M`  in  1  register write request from EX/MEM
- `mem_read_M`  out  32  aligned/extended load data to M_WB
- `RegW_gated_M`  out  1  `RegW_enable_M & ~stall_M & ~misalign_M`, to M_WB
- `stall_M`  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- `misalign_M`  out  1  misaligned access, no bus cycle issued
- `dmem_req`, `dmem_we`  out  1  bus request / write
- `dmem_addr`  out  32  `{ALU_result_M[31:2],2'b00}`
- `dmem_wdata`  out  32  lane-replicated store data
- `dmem_be`  out  4  byte enables
- `dmem_gnt`  in  1  request accepted
- `dmem_rvalid`  in  1  read data valid
- `dmem_rdata`  in  32  read data

## Operation
- Little-endian lanes. `be`: byte `4'b0001<<addr[1:0]`; half `addr[1]?1100:0011`; word `1111`.
- `wdata`: byte `{4{d[7:0]}}`, half `{2{d[15:0]}}`, word `d`.
- Load extract: select lane by `addr[1:0]` (half by `addr[1]`), sign-extend unless `unsigned_M`.
- Misaligned: half with `addr[0]`=1, word with `addr[1:0]`≠0. `misalign_M`=1 combinationally, FSM stays IDLE, `stall_M`=0, no request.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: aligned `MemR_M|MemW_M` → REQ, `stall_M`=1; otherwise `stall_M`=0.
  - REQ: `dmem_req`=1 (registered), `stall_M`=1. On `dmem_gnt`: store → DONE, load → WAIT.
  - WAIT: `stall_M`=1; on `dmem_rvalid`, capture `dmem_rdata` into `rdata_q` → DONE.
  - DONE: `stall_M`=0 (pipeline advances), → IDLE unconditionally; never re-issues for the same instruction.
- `mem_read_M` = extract(`rdata_q`, current `addr`, `size_M`, `unsigned_M`); `rdata_q` changes only on `rvalid` in WAIT.
- `MemR_M` and `MemW_M` both high: treated as store.

## Timing
- Reset values: state IDLE, `dmem_req`=0, `rdata_q`=0 → `mem_read_M`=0; `stall_M`, `misalign_M`, `RegW_gated_M` forced 0 while `rst`=1.
- Non-memory op: 0 stall cycles.
- Store, gnt in first REQ cycle: 2 stall cycles (IDLE, REQ), DONE on the 3rd cycle.
- Load, gnt immediately, rvalid next cycle: 3 stall cycles, data valid in DONE.
- Each extra cycle of gnt or rvalid latency adds one stall cycle.
- `dmem_addr/we/be/wdata` stable from the first REQ cycle until gnt. One outstanding transaction max.
- `rvalid` outside WAIT is ignored.
- Reset mid-transaction: IDLE next edge, `dmem_req` low, late `rvalid` dropped.

## Structure
- Package `mips_mem_pkg`: `size_M` encodings (`SZ_B`, `SZ_H`, `SZ_W`), FSM state enum.
- Sub-module `load_store_align` (combinational): `be`, `wdata` replication, load extraction, misalign detect. FSM and `rdata_q` in top.

## Test plan
- LW addr `0x100`, `rdata`=`0xDEADBEEF`, gnt immediate, rvalid +1 → 3 stall cycles, `mem_read_M`=`0xDEADBEEF`, `RegW_gated_M` high only in DONE.
- LB addr `0x103` `rdata`=`0x80FF1234` → `0xFFFFFF80`; LBU → `0x00000080`; LH addr `0x102` → `0xFFFF80FF`.
- SB addr `0x201` data `0x000000AB`, gnt after 3 cycles → `be`=`0010`, `wdata`=`0xABABABAB`, held stable, 4 stall cycles.
- LW addr `0x102` → `misalign_M`=1, no `dmem_req`, `stall_M`=0, `RegW_gated_M`=0.
- `rst` asserted in WAIT, `rvalid` the next cycle → IDLE, `dmem_req`=0, `rdata_q` stays 0.
- Back-to-back LW, SW → each issues exactly one request; no re-issue in DONE.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared encodings for the M-stage data access unit.
package mips_mem_pkg;

  // Access size encodings carried by size_M; 2'b11 is handled as a word.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Bus transaction sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } mem_state_t;

endpackage

// File: rtl/load_store_align.sv
// load_store_align: combinational byte-lane steering for M-stage loads and stores.
// Produces byte enables, lane-replicated store data, the extended load value and
// the misalignment flag from the low address bits and the access size.
module load_store_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_load_word,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data,
  output logic        o_misalign
);

  logic [7:0]  w_lane [4];
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi = gi + 1) begin : g_lane
      assign w_lane[gi] = i_load_word[8*gi +: 8];
    end
  endgenerate

  // Pick the addressed byte and halfword out of the fetched word (little-endian lanes).
  always_comb begin
    w_byte = w_lane[i_addr_lo];
    w_half = i_addr_lo[1] ? i_load_word[31:16] : i_load_word[15:0];
  end

  // Per-size lane enables, store replication, load extension and alignment check.
  always_comb begin
    o_be        = 4'b1111;
    o_wdata     = i_store_data;
    o_load_data = i_load_word;
    o_misalign  = |i_addr_lo;
    case (i_size)
      SZ_B: begin
        o_be        = 4'b0001 << i_addr_lo;
        o_wdata     = {4{i_store_data[7:0]}};
        o_load_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
        o_misalign  = 1'b0;
      end
      SZ_H: begin
        o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata     = {2{i_store_data[15:0]}};
        o_load_data = {{16{~i_unsigned & w_half[15]}}, w_half};
        o_misalign  = i_addr_lo[0];
      end
      default: begin
        // word (and the reserved encoding, which behaves as a word)
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: turns the M-stage load/store into one handshaked word-bus
// transaction, stalls the pipeline until it completes, and presents the aligned,
// extended load data plus a register-write enable gated to the completing cycle.
module mem_access_stage
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemR_M,
  input  logic              MemW_M,
  input  logic [1:0]        size_M,
  input  logic              unsigned_M,
  input  logic [ADDR_W-1:0] ALU_result_M,
  input  logic [DATA_W-1:0] write_data_M,
  input  logic              RegW_enable_M,
  output logic [DATA_W-1:0] mem_read_M,
  output logic              RegW_gated_M,
  output logic              stall_M,
  output logic              misalign_M,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata
);

  mem_state_t        r_state;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata_q;

  logic              w_mem_op;
  logic              w_misalign_raw;
  logic              w_start;
  logic              w_stall;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_load_data;

  // Lane steering is shared: store side from the live inputs, load side from rdata_q.
  load_store_align u_align (
    .i_addr_lo    (ALU_result_M[1:0]),
    .i_size       (size_M),
    .i_unsigned   (unsigned_M),
    .i_store_data (write_data_M),
    .i_load_word  (r_rdata_q),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data),
    .o_misalign   (w_misalign_raw)
  );

  assign w_mem_op = MemR_M | MemW_M;
  assign w_start  = w_mem_op & ~w_misalign_raw;

  // Transaction sequencer; bus fields are latched at issue so they hold until grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_rdata_q <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_REQ;
            r_req   <= 1'b1;
            // a simultaneous read+write request is performed as a store
            r_we    <= MemW_M;
            r_addr  <= {ALU_result_M[ADDR_W-1:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
          end
        end
        ST_REQ: begin
          if (dmem_gnt) begin
            r_req   <= 1'b0;
            r_state <= r_we ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dmem_rvalid) begin
            r_rdata_q <= dmem_rdata;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          // the pipeline advances this cycle, so the next instruction starts fresh
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Stall holds the pipeline from the first sight of an aligned access until DONE.
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      ST_IDLE: w_stall = w_start;
      ST_REQ:  w_stall = 1'b1;
      ST_WAIT: w_stall = 1'b1;
      default: w_stall = 1'b0;
    endcase
    if (rst) begin
      w_stall = 1'b0;
    end
  end

  assign stall_M      = w_stall;
  assign misalign_M   = w_mem_op & w_misalign_raw & ~rst;
  assign RegW_gated_M = RegW_enable_M & ~w_stall & ~misalign_M & ~rst;
  assign mem_read_M   = w_load_data;

  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_be    = r_be;
  assign dmem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized scoreboard bench for the M-stage access unit.
// A byte-addressed reference memory predicts load results, lane enables and
// stall lengths; a bus responder with its own word memory serves the DUT.
`timescale 1ns/1ps
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        MemR_M, MemW_M;
  logic [1:0]  size_M;
  logic        unsigned_M;
  logic [31:0] ALU_result_M, write_data_M;
  logic        RegW_enable_M;
  logic [31:0] mem_read_M;
  logic        RegW_gated_M, stall_M, misalign_M;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;

  mem_access_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .MemR_M(MemR_M), .MemW_M(MemW_M), .size_M(size_M), .unsigned_M(unsigned_M),
    .ALU_result_M(ALU_result_M), .write_data_M(write_data_M),
    .RegW_enable_M(RegW_enable_M),
    .mem_read_M(mem_read_M), .RegW_gated_M(RegW_gated_M),
    .stall_M(stall_M), .misalign_M(misalign_M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          stall;
    bit          is_load;
    logic [31:0] data;
    bit          regw;
    bit          mis;
  } comp_t;

  typedef struct {
    int          d;
    int          r;
    logic [31:0] addr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  comp_t       comp_q[$];
  bus_t        bus_q[$];
  logic [7:0]  ref_mem [0:1023];
  logic [31:0] bus_mem [0:255];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          mon_en   = 0;
  int          txn_no   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void flag(string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endfunction

  task automatic finish_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit ref_misaligned(logic [1:0] sz, logic [31:0] a);
    return (int'(a[1:0]) % nbytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(logic [31:0] a, logic [1:0] sz, bit uns);
    int n = nbytes(sz);
    int base = int'(a[9:0]);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[base + i];
    if (!uns && n < 4 && v[8*n-1])
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // Present one instruction in M, record what it must do, wait for it to retire.
  task automatic issue(input bit r, input bit w, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] d, input bit regw,
                       input int gd, input int rd);
    comp_t c;
    bus_t  b;
    bit    mem = r | w;
    bit    mis;
    int    n = nbytes(sz);
    int    cyc = 0;
    mis       = mem && ref_misaligned(sz, a);
    c.is_load = mem && !w && !mis;
    c.data    = c.is_load ? ref_load(a, sz, uns) : 32'h0;
    c.regw    = regw && !mis;
    c.mis     = mis;
    c.stall   = (!mem || mis) ? 0 : (w ? gd + 2 : gd + rd + 3);
    if (mem && !mis) begin
      b.d = gd; b.r = rd;
      b.addr = {a[31:2], 2'b00};
      b.we = w;
      b.be = 4'b0000;
      for (int i = 0; i < n; i++) b.be[int'(a[1:0]) + i] = 1'b1;
      for (int k = 0; k < 4; k++) b.wdata[8*k +: 8] = d[8*(k % n) +: 8];
      bus_q.push_back(b);
      if (w) for (int i = 0; i < n; i++) ref_mem[int'(a[9:0]) + i] = d[8*i +: 8];
    end
    comp_q.push_back(c);
    MemR_M = r; MemW_M = w; size_M = sz; unsigned_M = uns;
    ALU_result_M = a; write_data_M = d; RegW_enable_M = regw;
    txn_no++;
    $display("txn %0d: %s sz=%0d uns=%0d addr=0x%08h data=0x%08h regw=%0d gnt_dly=%0d rv_dly=%0d exp_stall=%0d",
             txn_no, !mem ? "ALU" : (w ? "STORE" : "LOAD"), sz, uns, a, d, regw, gd, rd, c.stall);
    forever begin
      @(negedge clk);
      if (!stall_M) break;
      cyc++;
      if (cyc > 60) begin
        flag("timeout waiting for stall_M to drop");
        finish_run();
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- completion monitor ----------------
  initial begin : monitor
    int    scnt;
    comp_t c;
    scnt = 0;
    forever begin
      @(negedge clk);
      if (!mon_en || rst) begin
        scnt = 0;
      end else if (stall_M) begin
        scnt++;
        chk("regw_during_stall", {31'h0, RegW_gated_M}, 32'h0);
      end else begin
        if (comp_q.size() == 0) begin
          flag("unexpected_completion");
        end else begin
          c = comp_q.pop_front();
          chk("stall_cycles", scnt, c.stall);
          chk("misalign", {31'h0, misalign_M}, {31'h0, c.mis});
          chk("regw_gated", {31'h0, RegW_gated_M}, {31'h0, c.regw});
          if (c.is_load) chk("load_data", mem_read_M, c.data);
        end
        scnt = 0;
      end
    end
  end

  // ---------------- bus responder ----------------
  initial begin : responder
    bus_t        cur;
    bit          in_req, gnt_issued, rd_pending;
    int          gcnt, rcnt;
    logic [31:0] g_addr, g_wdata, rd_word;
    logic [3:0]  g_be;
    bit          g_we;
    in_req = 0; gnt_issued = 0; rd_pending = 0; gcnt = 0; rcnt = 0;
    g_addr = 0; g_wdata = 0; g_be = 0; g_we = 0; rd_word = 0;
    for (int i = 0; i < 256; i++) bus_mem[i] = 32'h0;
    bus_mem[32'h100 >> 2] = 32'hDEADBEEF;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      dmem_rvalid = 1'b0;
      if (gnt_issued) begin
        gnt_issued = 0;
        dmem_gnt   = 1'b0;
        if (g_we) begin
          for (int k = 0; k < 4; k++)
            if (g_be[k]) bus_mem[g_addr[9:2]][8*k +: 8] = g_wdata[8*k +: 8];
        end else begin
          rd_pending = 1;
          rcnt       = cur.r;
          rd_word    = bus_mem[g_addr[9:2]];
        end
      end
      if (rd_pending) begin
        if (rcnt == 0) begin
          dmem_rvalid = 1'b1;
          dmem_rdata  = rd_word;
          rd_pending  = 0;
        end else begin
          rcnt--;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        // stray response while no read is outstanding
        dmem_rvalid = 1'b1;
        dmem_rdata  = $urandom;
      end
      if (rst) begin
        in_req = 0;
      end else if (dmem_req) begin
        if (!in_req) begin
          in_req = 1;
          if (bus_q.size() == 0) begin
            flag("unexpected bus request");
            cur.d = 0; cur.r = 0; cur.addr = dmem_addr; cur.we = dmem_we;
            cur.be = dmem_be; cur.wdata = dmem_wdata;
          end else begin
            cur = bus_q.pop_front();
          end
          gcnt = cur.d;
        end
        n_checks++;
        if (dmem_addr !== cur.addr || dmem_we !== cur.we || dmem_be !== cur.be ||
            dmem_wdata !== cur.wdata) begin
          n_errors++;
          $display("FAIL bus_fields: got addr=0x%08h we=%0d be=%b wdata=0x%08h, expected addr=0x%08h we=%0d be=%b wdata=0x%08h",
                   dmem_addr, dmem_we, dmem_be, dmem_wdata, cur.addr, cur.we, cur.be, cur.wdata);
        end
        if (gcnt == 0) begin
          dmem_gnt   = 1'b1;
          gnt_issued = 1;
          in_req     = 0;
          g_addr = dmem_addr; g_we = dmem_we; g_be = dmem_be; g_wdata = dmem_wdata;
        end else begin
          gcnt--;
        end
      end else begin
        in_req = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    bus_t        b;
    int          sel;
    logic [1:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    ref_mem[32'h100] = 8'hEF; ref_mem[32'h101] = 8'hBE;
    ref_mem[32'h102] = 8'hAD; ref_mem[32'h103] = 8'hDE;

    // reset with an aligned LW that would otherwise stall and write
    rst = 1'b1; MemR_M = 1'b1; MemW_M = 1'b0; size_M = 2'b10; unsigned_M = 1'b0;
    ALU_result_M = 32'h100; write_data_M = 32'h0; RegW_enable_M = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'h0, stall_M}, 32'h0);
    chk("rst_regw_gated", {31'h0, RegW_gated_M}, 32'h0);
    chk("rst_dmem_req", {31'h0, dmem_req}, 32'h0);
    chk("rst_mem_read", mem_read_M, 32'h0);
    ALU_result_M = 32'h102;
    @(negedge clk);
    chk("rst_misalign", {31'h0, misalign_M}, 32'h0);
    @(posedge clk); #1;

    // reset while waiting for read data; the late rvalid must be dropped
    rst = 1'b0; MemR_M = 1'b0; ALU_result_M = 32'h100;
    @(posedge clk); #1;
    b.d = 0; b.r = 1; b.addr = 32'h100; b.we = 0; b.be = 4'hF; b.wdata = 32'h0;
    bus_q.push_back(b);
    MemR_M = 1'b1;
    @(posedge clk);            // IDLE -> REQ
    @(posedge clk); #1;        // granted -> WAIT
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_wait_stall", {31'h0, stall_M}, 32'h0);
    chk("rst_in_wait_regw", {31'h0, RegW_gated_M}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; MemR_M = 1'b0;
    @(negedge clk);
    chk("post_rst_dmem_req", {31'h0, dmem_req}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("late_rvalid_dropped", mem_read_M, 32'h0);
    chk("post_rst_stall", {31'h0, stall_M}, 32'h0);
    chk("post_rst_dmem_req2", {31'h0, dmem_req}, 32'h0);
    @(posedge clk); #1;

    // directed cases
    mon_en = 1;
    issue(1, 0, 2'b10, 0, 32'h0000_0100, 32'h0, 1, 0, 0);       // LW -> DEADBEEF
    issue(0, 1, 2'b10, 0, 32'h0000_0100, 32'h80FF1234, 0, 0, 0);
    issue(1, 0, 2'b00, 0, 32'h0000_0103, 32'h0, 1, 1, 2);       // LB  -> FFFFFF80
    issue(1, 0, 2'b00, 1, 32'h0000_0103, 32'h0, 1, 0, 0);       // LBU -> 00000080
    issue(1, 0, 2'b01, 0, 32'h0000_0102, 32'h0, 1, 0, 1);       // LH  -> FFFF80FF
    issue(1, 0, 2'b01, 1, 32'h0000_0102, 32'h0, 1, 0, 0);       // LHU -> 000080FF
    issue(0, 1, 2'b00, 0, 32'h0000_0201, 32'h000000AB, 0, 2, 0); // SB, gnt late
    issue(1, 0, 2'b10, 0, 32'h0000_0200, 32'h0, 1, 0, 0);       // LW -> 0000AB00
    issue(1, 0, 2'b10, 0, 32'h0000_0102, 32'h0, 1, 0, 0);       // misaligned LW
    issue(0, 1, 2'b01, 0, 32'h0000_0105, 32'h1234, 0, 0, 0);    // misaligned SH
    issue(0, 0, 2'b10, 0, 32'h0000_0003, 32'h0, 1, 0, 0);       // ALU op
    issue(1, 0, 2'b10, 0, 32'h0000_0104, 32'h0, 1, 0, 0);       // back-to-back LW
    issue(0, 1, 2'b10, 0, 32'h0000_0108, 32'h5A5A_C3C3, 0, 0, 0); // then SW
    issue(1, 1, 2'b01, 0, 32'h0000_010A, 32'hBEEF, 1, 1, 0);    // both high -> store
    issue(1, 0, 2'b11, 0, 32'h0000_0108, 32'h0, 1, 0, 3);       // reserved size as word

    // randomized traffic
    for (int t = 0; t < 300; t++) begin
      sel = $urandom_range(0, 9);
      sz  = 2'($urandom_range(0, 3));
      a   = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~(nbytes(sz) - 1);
      issue(sel >= 2 && sel <= 5 || sel == 9, sel >= 6, sz, 1'($urandom_range(0, 1)),
            a, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    MemR_M = 1'b0; MemW_M = 1'b0; RegW_enable_M = 1'b0;
    mon_en = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", comp_q.size(), 32'h0);
    chk("bus_queue_drained", bus_q.size(), 32'h0);
    finish_run();
  end

endmodule
